// File: rtl/tcdm_responder.sv
// tcdm_responder: multi-port, word-interleaved TCDM memory model acting as the
// responder side of HWPE TCDM master ports. Per-bank round-robin arbitration
// grants in the request cycle; read data returns exactly one cycle after grant.
// Ports:
//   clk_i, rst_ni (async active-low), clear_i (sync clear of arbitration/response state)
//   req_i/add_i/wen_i/be_i/data_i : per-port request (wen=1 read, wen=0 write)
//   stall_i                       : per-port grant suppression for back-pressure injection
//   gnt_o                         : combinational grant in the request cycle
//   r_data_o/r_valid_o            : registered read response, one-cycle valid pulse
module tcdm_responder #(
  parameter int unsigned N_PORTS    = 6,
  parameter int unsigned N_BANKS    = 8,
  parameter int unsigned BANK_DEPTH = 256,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic [N_PORTS-1:0]            req_i,
  input  logic [N_PORTS*ADDR_WIDTH-1:0] add_i,
  input  logic [N_PORTS-1:0]            wen_i,
  input  logic [N_PORTS*4-1:0]          be_i,
  input  logic [N_PORTS*32-1:0]         data_i,
  input  logic [N_PORTS-1:0]            stall_i,
  output logic [N_PORTS-1:0]            gnt_o,
  output logic [N_PORTS*32-1:0]         r_data_o,
  output logic [N_PORTS-1:0]            r_valid_o
);

  localparam int unsigned BW = $clog2(N_BANKS);
  localparam int unsigned RW = $clog2(BANK_DEPTH);
  localparam int unsigned PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [BW-1:0]      bank_sel [N_PORTS];
  logic [RW-1:0]      row_sel  [N_PORTS];
  logic [N_PORTS-1:0] elig;

  logic [PW-1:0]      rr_ptr   [N_BANKS];
  logic [N_BANKS-1:0] bank_gnt;
  logic [PW-1:0]      bank_win [N_BANKS];
  logic [N_BANKS-1:0] win_wen;
  logic [RW-1:0]      win_row  [N_BANKS];
  logic [3:0]         win_be   [N_BANKS];
  logic [31:0]        win_data [N_BANKS];

  logic [31:0]        mem [N_BANKS][BANK_DEPTH];

  // Byte offset and address bits above the row field are deliberately ignored,
  // so the address space aliases modulo the total memory size.
  logic unused_addr;
  assign unused_addr = ^add_i;

  // Address decode and eligibility; clear suppresses every grant.
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      bank_sel[p] = add_i[p*ADDR_WIDTH+2 +: BW];
      row_sel[p]  = add_i[p*ADDR_WIDTH+2+BW +: RW];
      elig[p]     = req_i[p] && !stall_i[p] && !clear_i;
    end
  end

  // Per-bank round-robin: scan ports starting at the bank pointer, wrapping
  // modulo N_PORTS, and take the first eligible port addressing this bank.
  // The winner's payload is muxed out here so the memory write is per bank.
  always_comb begin
    int idx;
    idx      = 0;
    bank_gnt = '0;
    win_wen  = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      bank_win[b] = '0;
      win_row[b]  = '0;
      win_be[b]   = '0;
      win_data[b] = '0;
      for (int k = 0; k < N_PORTS; k++) begin
        idx = int'(rr_ptr[b]) + k;
        if (idx >= int'(N_PORTS)) idx = idx - int'(N_PORTS);
        if (!bank_gnt[b] && elig[idx] && (bank_sel[idx] == BW'(b))) begin
          bank_gnt[b] = 1'b1;
          bank_win[b] = PW'(idx);
          win_wen[b]  = wen_i[idx];
          win_row[b]  = row_sel[idx];
          win_be[b]   = be_i[idx*4 +: 4];
          win_data[b] = data_i[idx*32 +: 32];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      gnt_o[p] = elig[p] && bank_gnt[bank_sel[p]] && (bank_win[bank_sel[p]] == PW'(p));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < N_BANKS; b++) rr_ptr[b] <= '0;
    end else if (clear_i) begin
      for (int b = 0; b < N_BANKS; b++) rr_ptr[b] <= '0;
    end else begin
      for (int b = 0; b < N_BANKS; b++) begin
        if (bank_gnt[b]) begin
          rr_ptr[b] <= (bank_win[b] == PW'(N_PORTS-1)) ? '0 : bank_win[b] + 1'b1;
        end
      end
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < N_BANKS; b++) begin
      if (bank_gnt[b] && !win_wen[b]) begin
        for (int i = 0; i < 4; i++) begin
          if (win_be[b][i]) mem[b][win_row[b]][i*8 +: 8] <= win_data[b][i*8 +: 8];
        end
      end
    end
  end

  // The read samples the array before this edge's writes land, giving old data.
  // A read and a write never target the same bank in one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_o <= '0;
      r_data_o  <= '0;
    end else begin
      r_valid_o <= gnt_o & wen_i;
      for (int p = 0; p < N_PORTS; p++) begin
        if (gnt_o[p] && wen_i[p]) r_data_o[p*32 +: 32] <= mem[bank_sel[p]][row_sel[p]];
      end
    end
  end

endmodule
